// File: rtl/stage_monitor_pkg.sv
// Shared constants, error codes and helpers for the stage-enable protocol monitor.
package stage_monitor_pkg;

  localparam int unsigned NSTAGE    = 6;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [NSTAGE-1:0] STG_FETCH = 6'b000001;
  localparam logic [NSTAGE-1:0] STG_DEC   = 6'b000010;
  localparam logic [NSTAGE-1:0] STG_RGRD  = 6'b000100;
  localparam logic [NSTAGE-1:0] STG_ALU   = 6'b001000;
  localparam logic [NSTAGE-1:0] STG_RGWR  = 6'b010000;
  localparam logic [NSTAGE-1:0] STG_MEM   = 6'b100000;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_IDLE  = 2'b01,
    ERR_MULTI = 2'b10,
    ERR_ORDER = 2'b11
  } err_code_e;

  // Advance a one-hot stage vector; the memory stage wraps back to fetch.
  function automatic logic [NSTAGE-1:0] rotl1(input logic [NSTAGE-1:0] v);
    return {v[NSTAGE-2:0], v[NSTAGE-1]};
  endfunction

  // Stage index that follows idx, wrapping 5 -> 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NSTAGE - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/stage_onehot_chk.sv
// Combinational classifier of a stage-enable vector: zero, one-hot, multi-hot and index.
module stage_onehot_chk
  import stage_monitor_pkg::*;
(
  input  logic [NSTAGE-1:0] v,
  output logic              zero_c,
  output logic              onehot_c,
  output logic              multi_c,
  output logic [IDX_W-1:0]  idx_c
);

  logic [IDX_W-1:0] cnt;

  // Index reports the highest set bit; only meaningful when one-hot.
  always_comb begin
    cnt   = '0;
    idx_c = '0;
    for (int i = 0; i < int'(NSTAGE); i++) begin
      if (v[i]) begin
        cnt   = cnt + IDX_W'(1);
        idx_c = IDX_W'(i);
      end
    end
    zero_c   = (cnt == '0);
    onehot_c = (cnt == IDX_W'(1));
    multi_c  = (cnt > IDX_W'(1));
  end

endmodule

// File: rtl/stage_monitor.sv
// Passive checker of the six one-hot stage enables: tracks the expected stage,
// counts retired instructions and records protocol errors. Macro STAGE_MON_CYCLE_CNT_EN builds the cycle counter.
module stage_monitor
  import stage_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 I_clk,
  input  logic                 I_reset,
  input  logic                 I_enfetch,
  input  logic                 I_endec,
  input  logic                 I_enrgrd,
  input  logic                 I_enalu,
  input  logic                 I_enrgwr,
  input  logic                 I_enmem,
  input  logic                 I_clr,
  output logic [IDX_W-1:0]     O_stage_idx,
  output logic                 O_retire,
  output logic [CNT_W-1:0]     O_instr_count,
  output logic [CNT_W-1:0]     O_cycle_count,
  output logic                 O_err,
  output logic [1:0]           O_err_code,
  output logic [NSTAGE-1:0]    O_err_stage,
  output logic [ERR_CNT_W-1:0] O_err_count
);

  logic [NSTAGE-1:0]    v_c;
  logic                 v_zero_c;
  logic                 v_onehot_c;
  logic                 v_multi_c;
  logic [IDX_W-1:0]     v_idx_c;
  logic                 legal_c;
  err_code_e            ev_code_c;

  logic [NSTAGE-1:0]    e_q, e_d;
  logic [IDX_W-1:0]     stage_idx_q, stage_idx_d;
  logic                 retire_q, retire_d;
  logic [CNT_W-1:0]     instr_cnt_q, instr_cnt_d;
  logic                 err_q, err_d;
  err_code_e            err_code_q, err_code_d;
  logic [NSTAGE-1:0]    err_stage_q, err_stage_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign v_c = {I_enmem, I_enrgwr, I_enalu, I_enrgrd, I_endec, I_enfetch};

  stage_onehot_chk u_chk (
    .v        (v_c),
    .zero_c   (v_zero_c),
    .onehot_c (v_onehot_c),
    .multi_c  (v_multi_c),
    .idx_c    (v_idx_c)
  );

  // Classify the sample, move the expected stage and update the record.
  always_comb begin
    e_d         = e_q;
    stage_idx_d = stage_idx_q;
    retire_d    = 1'b0;
    instr_cnt_d = instr_cnt_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_stage_d = err_stage_q;
    err_cnt_d   = err_cnt_q;

    legal_c   = v_onehot_c && (v_c == e_q);
    ev_code_c = ERR_NONE;
    if (v_zero_c)        ev_code_c = ERR_IDLE;
    else if (v_multi_c)  ev_code_c = ERR_MULTI;
    else if (!legal_c)   ev_code_c = ERR_ORDER;

    // An out-of-order stage is trusted and tracking resyncs behind it.
    if (legal_c) begin
      e_d         = rotl1(e_q);
      stage_idx_d = next_idx(stage_idx_q);
    end else if (ev_code_c == ERR_ORDER) begin
      e_d         = rotl1(v_c);
      stage_idx_d = next_idx(v_idx_c);
    end

    if (I_clr) begin
      instr_cnt_d = '0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
      err_stage_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (legal_c && (e_q == STG_MEM)) begin
        retire_d    = 1'b1;
        instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end
      if (ev_code_c != ERR_NONE) begin
        if (!err_q) begin
          err_d       = 1'b1;
          err_code_d  = ev_code_c;
          err_stage_d = v_c;
        end
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      e_q         <= STG_FETCH;
      stage_idx_q <= '0;
      retire_q    <= 1'b0;
      instr_cnt_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_stage_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      e_q         <= e_d;
      stage_idx_q <= stage_idx_d;
      retire_q    <= retire_d;
      instr_cnt_q <= instr_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_stage_q <= err_stage_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef STAGE_MON_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    if (I_clr) cyc_cnt_d = '0;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) cyc_cnt_q <= '0;
    else         cyc_cnt_q <= cyc_cnt_d;
  end

  assign O_cycle_count = cyc_cnt_q;
`else
  assign O_cycle_count = '0;
`endif

  assign O_stage_idx   = stage_idx_q;
  assign O_retire      = retire_q;
  assign O_instr_count = instr_cnt_q;
  assign O_err         = err_q;
  assign O_err_code    = err_code_q;
  assign O_err_stage   = err_stage_q;
  assign O_err_count   = err_cnt_q;

endmodule

// File: tb/tb_stage_monitor.sv
// Self-checking bench for stage_monitor: directed scenarios plus randomized traffic
// against an index/integer reference model. Cycle-count expectations follow STAGE_MON_CYCLE_CNT_EN.
module tb_stage_monitor;

  localparam int unsigned CNT_W = 4;
  localparam int          MOD   = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             I_reset, I_clr;
  logic             I_enfetch, I_endec, I_enrgrd, I_enalu, I_enrgwr, I_enmem;
  logic [2:0]       O_stage_idx;
  logic             O_retire;
  logic [CNT_W-1:0] O_instr_count, O_cycle_count;
  logic             O_err;
  logic [1:0]       O_err_code;
  logic [5:0]       O_err_stage;
  logic [7:0]       O_err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected stage as a plain index, counters as ints.
  int m_idx, m_instr, m_cyc, m_code, m_stage, m_errcnt;
  bit m_retire, m_err;

  always #5 clk = ~clk;

  stage_monitor #(.CNT_W(CNT_W)) dut (
    .I_clk(clk), .I_reset(I_reset),
    .I_enfetch(I_enfetch), .I_endec(I_endec), .I_enrgrd(I_enrgrd),
    .I_enalu(I_enalu), .I_enrgwr(I_enrgwr), .I_enmem(I_enmem),
    .I_clr(I_clr),
    .O_stage_idx(O_stage_idx), .O_retire(O_retire),
    .O_instr_count(O_instr_count), .O_cycle_count(O_cycle_count),
    .O_err(O_err), .O_err_code(O_err_code), .O_err_stage(O_err_stage),
    .O_err_count(O_err_count)
  );

  function automatic logic [5:0] stage_vec(input int idx);
    logic [5:0] one;
    one = 6'b000001;
    return one << idx;
  endfunction

  task automatic model_update(input logic [5:0] v, input bit clr, input bit rst);
    int ones, pos, code;
    bit legal;
    if (rst) begin
      m_idx = 0; m_instr = 0; m_cyc = 0; m_code = 0; m_stage = 0;
      m_errcnt = 0; m_retire = 0; m_err = 0;
      return;
    end
    ones = $countones(v);
    pos  = 0;
    for (int i = 0; i < 6; i++) if (v[i]) pos = i;
    legal = (ones == 1) && (pos == m_idx);
    code  = (ones == 0) ? 1 : (ones > 1) ? 2 : (!legal) ? 3 : 0;
    if (clr) begin
      m_retire = 0; m_instr = 0; m_cyc = 0; m_err = 0; m_code = 0;
      m_stage = 0; m_errcnt = 0;
    end else begin
      m_retire = legal && (m_idx == 5);
      if (m_retire) m_instr = (m_instr + 1) % MOD;
`ifdef STAGE_MON_CYCLE_CNT_EN
      m_cyc = (m_cyc + 1) % MOD;
`endif
      if (code != 0) begin
        if (!m_err) begin
          m_err = 1; m_code = code; m_stage = int'(v);
        end
        if (m_errcnt < 255) m_errcnt++;
      end
    end
    if (legal)          m_idx = (m_idx + 1) % 6;
    else if (code == 3) m_idx = (pos + 1) % 6;
  endtask

  task automatic step(input logic [5:0] v, input bit clr, input bit rst);
    {I_enmem, I_enrgwr, I_enalu, I_enrgrd, I_endec, I_enfetch} = v;
    I_clr   = clr;
    I_reset = rst;
    @(posedge clk);
    model_update(v, clr, rst);
    #1;
  endtask

  task automatic test_reset();
    step(6'($urandom), 1'b0, 1'b1);
    step(6'($urandom), 1'b1, 1'b1);
    checks++;
    if (O_stage_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", O_stage_idx); end
    checks++;
    if ({O_retire, O_instr_count, O_cycle_count, O_err, O_err_code, O_err_stage, O_err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got retire=%0d instr=%0d cyc=%0d err=%0d code=%0d stage=%b errcnt=%0d expected all 0",
               O_retire, O_instr_count, O_cycle_count, O_err, O_err_code, O_err_stage, O_err_count);
    end
  endtask

  task automatic test_legal();
    int pulses = 0;
    step(6'b0, 1'b0, 1'b1);
    for (int k = 0; k < 18; k++) begin
      step(stage_vec(k % 6), 1'b0, 1'b0);
      checks++;
      if (O_retire !== (k % 6 == 5)) begin
        errors++; $display("FAIL legal_retire: cycle %0d got %0d expected %0d", k, O_retire, (k % 6 == 5));
      end
      if (O_retire) pulses++;
    end
    checks++;
    if (O_instr_count !== 4'd3) begin errors++; $display("FAIL legal_instr: got %0d expected 3", O_instr_count); end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL legal_pulses: got %0d expected 3", pulses); end
    checks++;
    if (O_err !== 1'b0) begin errors++; $display("FAIL legal_err: got %0d expected 0", O_err); end
  endtask

  task automatic test_idle();
    step(6'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(stage_vec(k), 1'b0, 1'b0);
    step(6'b0, 1'b0, 1'b0);
    checks++;
    if ({O_err, O_err_code, O_err_stage, O_err_count} !== {1'b1, 2'b01, 6'b0, 8'd1}) begin
      errors++;
      $display("FAIL idle_record: got err=%0d code=%b stage=%b cnt=%0d expected 1 01 000000 1",
               O_err, O_err_code, O_err_stage, O_err_count);
    end
    checks++;
    if (O_stage_idx !== 3'd3) begin errors++; $display("FAIL idle_hold: got %0d expected 3", O_stage_idx); end
    for (int k = 3; k < 6; k++) step(stage_vec(k), 1'b0, 1'b0);
    checks++;
    if ({O_retire, O_instr_count, O_err_count} !== {1'b1, 4'd1, 8'd1}) begin
      errors++;
      $display("FAIL idle_resume: got retire=%0d instr=%0d errcnt=%0d expected 1 1 1", O_retire, O_instr_count, O_err_count);
    end
  endtask

  task automatic test_multi_order();
    step(6'b0, 1'b0, 1'b1);
    step(6'b000001, 1'b0, 1'b0);
    step(6'b000010, 1'b0, 1'b0);
    step(6'b000110, 1'b0, 1'b0);
    checks++;
    if (O_stage_idx !== 3'd2) begin errors++; $display("FAIL multi_hold: got %0d expected 2", O_stage_idx); end
    step(6'b010000, 1'b0, 1'b0);
    checks++;
    if ({O_err_code, O_err_stage} !== {2'b10, 6'b000110}) begin
      errors++; $display("FAIL first_err_kept: got code=%b stage=%b expected 10 000110", O_err_code, O_err_stage);
    end
    checks++;
    if (O_err_count !== 8'd2) begin errors++; $display("FAIL order_errcnt: got %0d expected 2", O_err_count); end
    checks++;
    if (O_stage_idx !== 3'd5) begin errors++; $display("FAIL order_resync: got %0d expected 5", O_stage_idx); end
    step(6'b100000, 1'b0, 1'b0);
    checks++;
    if ({O_retire, O_err_count} !== {1'b1, 8'd2}) begin
      errors++; $display("FAIL resync_mem: got retire=%0d errcnt=%0d expected 1 2", O_retire, O_err_count);
    end
  endtask

  task automatic test_clr();
    step(6'b0, 1'b0, 1'b1);
    for (int k = 0; k < 47; k++) step(stage_vec(k % 6), 1'b0, 1'b0);
    checks++;
    if (O_instr_count !== 4'd7) begin errors++; $display("FAIL clr_pre: got %0d expected 7", O_instr_count); end
    step(6'b100000, 1'b1, 1'b0);
    checks++;
    if ({O_instr_count, O_retire, O_err} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL clr_drop: got instr=%0d retire=%0d err=%0d expected 0 0 0", O_instr_count, O_retire, O_err);
    end
    checks++;
    if (O_stage_idx !== 3'd0) begin errors++; $display("FAIL clr_advance: got %0d expected 0", O_stage_idx); end
  endtask

  task automatic test_saturate();
    step(6'b0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) step(6'b0, 1'b0, 1'b0);
    checks++;
    if ({O_err_count, O_err, O_err_code} !== {8'd255, 1'b1, 2'b01}) begin
      errors++; $display("FAIL sat_count: got cnt=%0d err=%0d code=%b expected 255 1 01", O_err_count, O_err, O_err_code);
    end
    step(6'b000110, 1'b0, 1'b1);
    checks++;
    if ({O_stage_idx, O_retire, O_instr_count, O_cycle_count, O_err, O_err_code, O_err_stage, O_err_count} !== '0) begin
      errors++; $display("FAIL sat_reset: got idx=%0d errcnt=%0d err=%0d expected all 0", O_stage_idx, O_err_count, O_err);
    end
  endtask

  task automatic test_wrap();
    int exp_cyc;
    step(6'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 96; k++) begin
      step(stage_vec((k - 1) % 6), 1'b0, 1'b0);
`ifdef STAGE_MON_CYCLE_CNT_EN
      exp_cyc = k % 16;
`else
      exp_cyc = 0;
`endif
      if (k <= 17) begin
        checks++;
        if (O_cycle_count !== 4'(exp_cyc)) begin
          errors++; $display("FAIL cycle_wrap: step %0d got %0d expected %0d", k, O_cycle_count, exp_cyc);
        end
      end
      if (k % 6 == 0) begin
        checks++;
        if (O_instr_count !== 4'((k / 6) % 16)) begin
          errors++; $display("FAIL instr_wrap: step %0d got %0d expected %0d", k, O_instr_count, (k / 6) % 16);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] v;
    int r;
    bit clr, rst;
    step(6'b0, 1'b0, 1'b1);
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      v = stage_vec(m_idx);
      else if (r < 80) v = stage_vec(int'($urandom_range(0, 5)));
      else if (r < 88) v = 6'b0;
      else begin
        v = 6'($urandom);
        while ($countones(v) < 2) v = 6'($urandom);
      end
      clr = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 199) < 1);
      step(v, clr, rst);
      checks++;
      if (O_stage_idx !== 3'(m_idx)) begin errors++; $display("FAIL rnd_idx: k=%0d got %0d expected %0d", k, O_stage_idx, m_idx); end
      checks++;
      if (O_retire !== m_retire) begin errors++; $display("FAIL rnd_retire: k=%0d got %0d expected %0d", k, O_retire, m_retire); end
      checks++;
      if (O_instr_count !== 4'(m_instr)) begin errors++; $display("FAIL rnd_instr: k=%0d got %0d expected %0d", k, O_instr_count, m_instr); end
      checks++;
      if (O_cycle_count !== 4'(m_cyc)) begin errors++; $display("FAIL rnd_cycle: k=%0d got %0d expected %0d", k, O_cycle_count, m_cyc); end
      checks++;
      if (O_err !== m_err) begin errors++; $display("FAIL rnd_err: k=%0d got %0d expected %0d", k, O_err, m_err); end
      checks++;
      if (O_err_code !== 2'(m_code)) begin errors++; $display("FAIL rnd_code: k=%0d got %0d expected %0d", k, O_err_code, m_code); end
      checks++;
      if (O_err_stage !== 6'(m_stage)) begin errors++; $display("FAIL rnd_stage: k=%0d got %b expected %b", k, O_err_stage, 6'(m_stage)); end
      checks++;
      if (O_err_count !== 8'(m_errcnt)) begin errors++; $display("FAIL rnd_errcnt: k=%0d got %0d expected %0d", k, O_err_count, m_errcnt); end
    end
  endtask

  initial begin
    I_reset = 1'b1;
    I_clr   = 1'b0;
    {I_enmem, I_enrgwr, I_enalu, I_enrgrd, I_endec, I_enfetch} = 6'b0;
    test_reset();
    test_legal();
    test_idle();
    test_multi_order();
    test_clr();
    test_saturate();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_monitor.md
# stage_monitor

- Passive checker on the six one-hot stage enables driven by the processor's control unit: fetch, decode, register-read, ALU, register-write and memory.
- Tracks the expected stage sequence and counts retired instructions (legal memory stages).
- Detects and records protocol violations: idle cycle, multiple enables, out-of-order stage.
- Sits beside the core datapath as the consuming end of the stage-enable interface; it never drives the core.

## Interface

Clock: one clock. Reset: synchronous, active-high.

Parameters
- CNT_W, 16, width of the instruction and cycle counters

Ports
- I_clk  input  1  clock
- I_reset  input  1  synchronous active-high reset
- I_enfetch  input  1  fetch stage enable
- I_endec  input  1  decode stage enable
- I_enrgrd  input  1  register-read stage enable
- I_enalu  input  1  ALU stage enable
- I_enrgwr  input  1  register-write stage enable
- I_enmem  input  1  memory stage enable
- I_clr  input  1  synchronous clear of counters and error record
- O_stage_idx  output  3  index 0..5 of the expected stage in the current cycle
- O_retire  output  1  one-cycle pulse, one cycle after a legal memory stage
- O_instr_count  output  CNT_W  legal memory stages seen; wraps
- O_cycle_count  output  CNT_W  cycles since reset/clear; wraps (feature-gated)
- O_err  output  1  sticky error flag
- O_err_code  output  2  code of the first error: 01 idle, 10 multi-hot, 11 out-of-order
- O_err_stage  output  6  enable vector captured at the first error
- O_err_count  output  8  total errors, saturating at 255

## Operation

- Inputs: V = {I_enmem, I_enrgwr, I_enalu, I_enrgrd, I_endec, I_enfetch}.
- Expected-stage register E (6-bit one-hot); O_stage_idx is the binary encode of E.
- Each non-reset cycle, classify V against E:
  - V == E (legal): E rotates left, with 100000 wrapping to 000001. If V == 100000, the instruction counter increments and O_retire pulses.
  - V == 0 (idle, code 01): E is held.
  - popcount(V) > 1 (multi-hot, code 10): E is held.
  - V one-hot but V != E (out-of-order, code 11): E resyncs to rotate-left(V). A memory stage seen here does not retire.
- Error record:
  - On the first error, set O_err and capture O_err_code and O_err_stage. Later errors do not overwrite these.
  - O_err_count increments on every error and saturates at 255.
- I_clr:
  - Zeroes instr/cycle/error counters, O_err, O_err_code, O_err_stage and O_retire.
  - I_clr has priority over any increment or capture in the same cycle; that cycle's event is dropped.
  - E still updates normally during I_clr.
- I_reset:
  - E = 000001, so it is aligned with the control unit's reset state.
  - All outputs are 0, except O_stage_idx = 0.
  - Inputs are ignored in the reset cycle.
  - Reset mid-sequence discards all tracking.

## Timing

- All outputs are registered.
- Effects of the cycle-N sample (O_retire, counter updates, error capture) are visible in cycle N+1.
- O_stage_idx reflects E for the current cycle, i.e. the stage expected at the next rising edge.
- Back-to-back instructions: a retire occurs every 6 cycles; O_retire is never high on two consecutive cycles.
- Wrap-around:
  - O_instr_count goes from 2^CNT_W-1 to 0, with no flag.
  - O_cycle_count wraps the same way.

## Configuration

- Macro: STAGE_MON_CYCLE_CNT_EN.
- Defined: O_cycle_count increments every non-reset, non-clear cycle.
- Undefined: the counter is not built and O_cycle_count is tied to 0. The port is present in both builds.

## Structure

- Shared package holds:
  - NSTAGE = 6.
  - One-hot constants STG_FETCH through STG_MEM.
  - Error codes ERR_NONE, ERR_IDLE, ERR_MULTI, ERR_ORDER.
  - The 8-bit error-count width.
- One sub-module, stage_onehot_chk, purely combinational. From V it produces zero, one-hot and multi-hot flags plus a 3-bit index.
- The stage_monitor top holds E, the counters and the error record.

## Test plan

1. Reset, then a legal sequence for 3 instructions (18 cycles):
   - O_instr_count = 3 and O_retire pulses 3 times, each 6 cycles apart.
   - O_err = 0.
2. Drive V = 0 at cycle 3 after reset:
   - O_err = 1, O_err_code = 01, O_err_stage = 000000, O_err_count = 1.
   - O_stage_idx stays at 3, and the sequence resumes at stage 3.
3. Drive V = 000110, then V = 010000 while E = 000100:
   - The first error is recorded as code 10 with stage 000110; code 11 does not overwrite it.
   - O_err_count = 2, and E = 100000 afterwards.
4. Assert I_clr in the same cycle as a legal memory stage with instr count = 7:
   - Next cycle: O_instr_count = 0, O_retire = 0.
   - O_stage_idx = 0, because E has advanced.
5. Force 300 idle cycles:
   - O_err_count saturates at 255.
   - I_reset then returns all outputs to 0 and E to 000001.
6. With STAGE_MON_CYCLE_CNT_EN and CNT_W = 4, run 16 cycles:
   - O_cycle_count wraps 15 → 0.
   - Without the macro, O_cycle_count stays at 0.
